// File: rtl/adc_sched_pkg.sv
// Shared constants and enumerations for the MCP3008 scan scheduler.
package adc_sched_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = 3;
    localparam int ADC_W  = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        STORE = 2'd3
    } sched_state_t;

    typedef enum logic {
        REQ_SCAN = 1'b0,
        REQ_HOST = 1'b1
    } requester_t;

endpackage

// File: rtl/adc_sample_timer.sv
// Free-running scan-rate timer: counts 0..PERIOD-1 while enabled and
// emits a single-cycle tick on the wrap cycle.
module adc_sample_timer #(
    parameter int PERIOD = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    output logic tick_o
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             wrap;

    assign wrap = (count_q == CNT_W'(PERIOD - 1));

    always_comb begin
        count_d = count_q;
        if (!enable_i || wrap) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = enable_i && wrap;

endmodule

// File: rtl/adc_scan_scheduler.sv
// Sequences the MCP3008 SPI engine: periodic channel-mask scans plus
// one-shot host conversions, alternating fairly when both compete.
module adc_scan_scheduler
    import adc_sched_pkg::*;
#(
    parameter int SAMPLE_PERIOD_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES       = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] chan_mask,
    input  logic              single_ended,
    input  logic              host_req,
    input  logic [CH_W-1:0]   host_channel,
    output logic              host_ack,
    output logic              host_valid,
    output logic [ADC_W-1:0]  host_data,
    output logic              conv_start,
    output logic [CH_W-1:0]   conv_channel,
    output logic              conv_single,
    input  logic              conv_busy,
    input  logic              conv_done,
    input  logic [ADC_W-1:0]  conv_data,
    output logic              sample_valid,
    output logic [CH_W-1:0]   sample_channel,
    output logic [ADC_W-1:0]  sample_data,
    output logic              scan_done,
    output logic              overrun,
    output logic              timeout_err,
    input  logic              clear_err
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    sched_state_t      state_q, state_d;
    requester_t        req_q, req_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic              single_q, single_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              abort_q, abort_d;
    logic              host_ack_q, host_ack_d;
    logic [ADC_W-1:0]  host_data_q, host_data_d;
    logic [CH_W-1:0]   sample_ch_q, sample_ch_d;
    logic [ADC_W-1:0]  sample_data_q, sample_data_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;

    logic              tick;
    logic              pick_host;
    logic              overrun_set;
    logic              timeout_set;
    logic [NUM_CH-1:0] sel_clear;
    logic [NUM_CH-1:0] pending_after;
    logic [NUM_CH-1:0] low_onehot;
    logic [CH_W-1:0]   low_idx;

    adc_sample_timer #(
        .PERIOD (SAMPLE_PERIOD_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .enable_i (enable),
        .tick_o   (tick)
    );

    // Two's-complement trick isolates the lowest pending channel.
    assign low_onehot = pending_q & (~pending_q + NUM_CH'(1));

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (low_onehot[i]) begin
                low_idx = CH_W'(i);
            end
        end
    end

    // The host yields once after its own conversion if a scan is pending.
    assign pick_host = host_req && !((req_q == REQ_HOST) && (pending_q != '0));

    always_comb begin
        state_d       = state_q;
        req_d         = req_q;
        chan_d        = chan_q;
        single_d      = single_q;
        wait_cnt_d    = wait_cnt_q;
        abort_d       = abort_q;
        host_ack_d    = 1'b0;
        host_data_d   = host_data_q;
        sample_ch_d   = sample_ch_q;
        sample_data_d = sample_data_q;
        sel_clear     = '0;
        timeout_set   = 1'b0;
        overrun_set   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_host) begin
                    req_d      = REQ_HOST;
                    chan_d     = host_channel;
                    single_d   = single_ended;
                    host_ack_d = 1'b1;
                    state_d    = ISSUE;
                end else if (pending_q != '0) begin
                    req_d     = REQ_SCAN;
                    chan_d    = low_idx;
                    single_d  = single_ended;
                    sel_clear = low_onehot;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!conv_busy) begin
                    wait_cnt_d = '0;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (conv_done) begin
                    abort_d = 1'b0;
                    state_d = STORE;
                    if (req_q == REQ_HOST) begin
                        host_data_d = conv_data;
                    end else begin
                        sample_ch_d   = chan_q;
                        sample_data_d = conv_data;
                    end
                end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    abort_d     = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = STORE;
                    if (req_q == REQ_HOST) begin
                        host_data_d = '0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        pending_after = pending_q & ~sel_clear;
        if (!enable) begin
            pending_d = '0;
        end else if (tick) begin
            overrun_set = (pending_after != '0);
            pending_d   = chan_mask;
        end else begin
            pending_d = pending_after;
        end

        overrun_d = clear_err ? 1'b0 : (overrun_q | overrun_set);
        timeout_d = clear_err ? 1'b0 : (timeout_q | timeout_set);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            req_q         <= REQ_SCAN;
            chan_q        <= '0;
            single_q      <= 1'b0;
            pending_q     <= '0;
            wait_cnt_q    <= '0;
            abort_q       <= 1'b0;
            host_ack_q    <= 1'b0;
            host_data_q   <= '0;
            sample_ch_q   <= '0;
            sample_data_q <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_q         <= req_d;
            chan_q        <= chan_d;
            single_q      <= single_d;
            pending_q     <= pending_d;
            wait_cnt_q    <= wait_cnt_d;
            abort_q       <= abort_d;
            host_ack_q    <= host_ack_d;
            host_data_q   <= host_data_d;
            sample_ch_q   <= sample_ch_d;
            sample_data_q <= sample_data_d;
            overrun_q     <= overrun_d;
            timeout_q     <= timeout_d;
        end
    end

    assign conv_start     = (state_q == ISSUE) && !conv_busy;
    assign conv_channel   = chan_q;
    assign conv_single    = single_q;
    assign host_ack       = host_ack_q;
    assign host_valid     = (state_q == STORE) && (req_q == REQ_HOST);
    assign host_data      = host_data_q;
    assign sample_valid   = (state_q == STORE) && (req_q == REQ_SCAN) && !abort_q;
    assign sample_channel = sample_ch_q;
    assign sample_data    = sample_data_q;
    assign scan_done      = (state_q == STORE) && (req_q == REQ_SCAN) && (pending_q == '0);
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_q;

endmodule
